// File: rtl/dff_pipe.sv
// dff_pipe: an elastic, bubble-collapsing register pipeline with valid/ready
// handshakes on both ends.
//
// Each of the DEPTH stages holds one WIDTH-bit data word and one valid flag.
// Stage 0 captures d XOR NEGATE on an input transfer. An item moves forward
// one stage per clock edge whenever the stage ahead is empty or is itself
// moving on, so empty stages fill from the output end. An item accepted at
// edge k reaches the output stage after edge k+DEPTH-1, and the pipeline
// sustains one item per cycle.
//
// Parameters
//   WIDTH  : number of independent data channels (1..64)
//   DEPTH  : number of register stages (1..16)
//   NEGATE : per-channel inversion mask, applied at capture
//   REDUCE : q_red function; 0 = constant 0, 1 = AND, 2 = OR, 3 = XOR of q
//
// Ports
//   c         : clock; all state changes on its rising edge
//   r         : synchronous active-high reset
//   in_valid  : d carries a valid item
//   in_ready  : the pipe accepts d this cycle (combinational from out_ready)
//   d         : input data
//   out_valid : q holds a valid item
//   out_ready : the consumer takes q this cycle
//   q         : output data (last-stage register)
//   q_red     : reduction of q selected by REDUCE, independent of out_valid
//   count     : number of occupied stages
module dff_pipe #(
    parameter int              WIDTH  = 2,
    parameter int              DEPTH  = 2,
    parameter logic [WIDTH-1:0] NEGATE = '0,
    parameter logic [1:0]      REDUCE = 2'd1
) (
    input  logic                           c,
    input  logic                           r,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               d,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               q,
    output logic                           q_red,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_din [DEPTH];
    logic [DEPTH-1:0] w_adv;      // stage k hands its item on this edge
    logic [DEPTH-1:0] w_load;     // stage k captures a new item this edge
    logic [DEPTH-1:0] w_vld_nxt;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // Advance decisions ripple from the output end backwards: a stage may
    // move on if the stage ahead is empty or is moving on in the same cycle.
    always_comb begin
        w_adv     = '0;
        w_load    = '0;
        w_vld_nxt = r_vld;

        w_out_fire         = r_vld[DEPTH-1] & out_ready;
        w_adv[DEPTH-1]     = w_out_fire;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = r_vld[k] & (~r_vld[k+1] | w_adv[k+1]);
        end

        w_in_ready = ~r_vld[0] | w_adv[0];
        w_in_fire  = in_valid & w_in_ready;

        w_load[0] = w_in_fire;
        w_din[0]  = d ^ NEGATE;
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1];
            w_din[k]  = r_data[k-1];
        end

        for (int k = 0; k < DEPTH; k++) begin
            w_vld_nxt[k] = w_load[k] | (r_vld[k] & ~w_adv[k]);
        end
    end

    // Reset clears data as well as control so q reads 0 after reset.
    always_ff @(posedge c) begin
        if (r) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_vld <= w_vld_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= w_din[k];
                end
            end
            case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        case (REDUCE)
            2'd1:    q_red = &r_data[DEPTH-1];
            2'd2:    q_red = |r_data[DEPTH-1];
            2'd3:    q_red = ^r_data[DEPTH-1];
            default: q_red = 1'b0;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_vld[DEPTH-1];
    assign q         = r_data[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe. Instance A: WIDTH=2, DEPTH=2, NEGATE=2'b01, REDUCE=AND,
// driven from a vector table. Instance B: WIDTH=3, DEPTH=4, NEGATE=0,
// REDUCE=XOR, driven by a hand-written sequence for latency and stall holds.
module tb_dff_pipe;

    logic c = 1'b0;
    always #5 c = ~c;

    // Instance A signals
    logic       ra, iva, ora;
    logic [1:0] da;
    logic       ira, ova, reda;
    logic [1:0] qa;
    logic [1:0] cnta;

    // Instance B signals
    logic       rb, ivb, orb;
    logic [2:0] db;
    logic       irb, ovb, redb;
    logic [2:0] qb;
    logic [2:0] cntb;

    dff_pipe #(.WIDTH(2), .DEPTH(2), .NEGATE(2'b01), .REDUCE(2'd1)) u_a (
        .c(c), .r(ra), .in_valid(iva), .in_ready(ira), .d(da),
        .out_valid(ova), .out_ready(ora), .q(qa), .q_red(reda), .count(cnta)
    );

    dff_pipe #(.WIDTH(3), .DEPTH(4), .NEGATE(3'b000), .REDUCE(2'd3)) u_b (
        .c(c), .r(rb), .in_valid(ivb), .in_ready(irb), .d(db),
        .out_valid(ovb), .out_ready(orb), .q(qb), .q_red(redb), .count(cntb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic       iv;
        logic [1:0] d;
        logic       ordy;
        logic       chk_ir;
        logic       ir;
        logic       ov;
        logic [1:0] q;
        logic       red;
        logic [1:0] cnt;
    } vec_t;

    function automatic vec_t v(input logic r_i, input logic iv_i, input logic [1:0] d_i,
                               input logic or_i, input logic chk_i, input logic ir_i,
                               input logic ov_i, input logic [1:0] q_i,
                               input logic red_i, input logic [1:0] cnt_i);
        vec_t t;
        t.r = r_i; t.iv = iv_i; t.d = d_i; t.ordy = or_i; t.chk_ir = chk_i;
        t.ir = ir_i; t.ov = ov_i; t.q = q_i; t.red = red_i; t.cnt = cnt_i;
        return t;
    endfunction

    localparam int NV = 24;
    vec_t tv [NV];

    // One cycle on instance B: drive, check in_ready before the edge,
    // clock, then check the registered outputs.
    task automatic b_cycle(input int idx, input logic iv_i, input logic [2:0] d_i,
                           input logic or_i, input logic ir_e, input logic ov_e,
                           input logic [2:0] q_e, input logic red_e,
                           input logic [2:0] cnt_e);
        ivb = iv_i; db = d_i; orb = or_i;
        #1;
        chk("B.in_ready", idx, 64'(irb), 64'(ir_e));
        @(posedge c);
        #1;
        chk("B.out_valid", idx, 64'(ovb), 64'(ov_e));
        chk("B.q", idx, 64'(qb), 64'(q_e));
        chk("B.q_red", idx, 64'(redb), 64'(red_e));
        chk("B.count", idx, 64'(cntb), 64'(cnt_e));
    endtask

    initial begin
        // Fields: r, iv, d, out_ready, check_ir, ir, ov, q, q_red, count
        // Reset, then idle after reset.
        tv[0]  = v(1, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'd0);
        tv[1]  = v(0, 0, 2'b00, 1, 1, 1, 0, 2'b00, 0, 2'd0);
        // Single item 10 -> stored 11, visible after one more edge.
        tv[2]  = v(0, 1, 2'b10, 1, 1, 1, 0, 2'b00, 0, 2'd1);
        tv[3]  = v(0, 0, 2'b00, 1, 1, 1, 1, 2'b11, 1, 2'd1);
        tv[4]  = v(0, 0, 2'b00, 1, 1, 1, 0, 2'b11, 1, 2'd0);
        // Back-to-back stream 00,01,10,11 -> 01,00,11,10.
        tv[5]  = v(0, 1, 2'b00, 1, 1, 1, 0, 2'b11, 1, 2'd1);
        tv[6]  = v(0, 1, 2'b01, 1, 1, 1, 1, 2'b01, 0, 2'd2);
        tv[7]  = v(0, 1, 2'b10, 1, 1, 1, 1, 2'b00, 0, 2'd2);
        tv[8]  = v(0, 1, 2'b11, 1, 1, 1, 1, 2'b11, 1, 2'd2);
        tv[9]  = v(0, 0, 2'b00, 1, 1, 1, 1, 2'b10, 0, 2'd1);
        tv[10] = v(0, 0, 2'b00, 1, 1, 1, 0, 2'b10, 0, 2'd0);
        // out_ready=0: two accepted, third stalls (d wiggles while stalled),
        // then accepted on the edge that emits the first.
        tv[11] = v(0, 1, 2'b01, 0, 1, 1, 0, 2'b10, 0, 2'd1);
        tv[12] = v(0, 1, 2'b10, 0, 1, 1, 1, 2'b00, 0, 2'd2);
        tv[13] = v(0, 1, 2'b11, 0, 1, 0, 1, 2'b00, 0, 2'd2);
        tv[14] = v(0, 1, 2'b00, 0, 1, 0, 1, 2'b00, 0, 2'd2);
        tv[15] = v(0, 1, 2'b11, 1, 1, 1, 1, 2'b11, 1, 2'd2);
        tv[16] = v(0, 0, 2'b00, 1, 1, 1, 1, 2'b10, 0, 2'd1);
        tv[17] = v(0, 0, 2'b00, 1, 1, 1, 0, 2'b10, 0, 2'd0);
        // Fill, then reset with in_valid=1; next item is first out.
        tv[18] = v(0, 1, 2'b00, 0, 1, 1, 0, 2'b10, 0, 2'd1);
        tv[19] = v(0, 1, 2'b01, 0, 1, 1, 1, 2'b01, 0, 2'd2);
        tv[20] = v(1, 1, 2'b11, 0, 1, 0, 0, 2'b00, 0, 2'd0);
        tv[21] = v(0, 1, 2'b10, 1, 1, 1, 0, 2'b00, 0, 2'd1);
        tv[22] = v(0, 0, 2'b00, 1, 1, 1, 1, 2'b11, 1, 2'd1);
        tv[23] = v(0, 0, 2'b00, 1, 1, 1, 0, 2'b11, 1, 2'd0);

        ra = 1'b1; iva = 1'b0; da = 2'b00; ora = 1'b0;
        rb = 1'b1; ivb = 1'b0; db = 3'b000; orb = 1'b0;

        @(posedge c);
        #1;
        for (int i = 0; i < NV; i++) begin
            ra = tv[i].r; iva = tv[i].iv; da = tv[i].d; ora = tv[i].ordy;
            #1;
            if (tv[i].chk_ir) chk("A.in_ready", i, 64'(ira), 64'(tv[i].ir));
            @(posedge c);
            #1;
            chk("A.out_valid", i, 64'(ova), 64'(tv[i].ov));
            chk("A.q", i, 64'(qa), 64'(tv[i].q));
            chk("A.q_red", i, 64'(reda), 64'(tv[i].red));
            chk("A.count", i, 64'(cnta), 64'(tv[i].cnt));
        end
        iva = 1'b0;

        // Instance B has been held in reset throughout the table.
        rb = 1'b0;
        b_cycle(0,  0, 3'b000, 0, 1, 0, 3'b000, 0, 3'd0);
        // One item into an empty DEPTH=4 pipe with out_ready=0.
        b_cycle(1,  1, 3'b111, 0, 1, 0, 3'b000, 0, 3'd1);
        b_cycle(2,  0, 3'b000, 0, 1, 0, 3'b000, 0, 3'd1);
        b_cycle(3,  0, 3'b000, 0, 1, 0, 3'b000, 0, 3'd1);
        b_cycle(4,  0, 3'b000, 0, 1, 1, 3'b111, 1, 3'd1);
        b_cycle(5,  0, 3'b000, 0, 1, 1, 3'b111, 1, 3'd1);
        // Second item collapses up behind the held one.
        b_cycle(6,  1, 3'b110, 0, 1, 1, 3'b111, 1, 3'd2);
        b_cycle(7,  0, 3'b000, 0, 1, 1, 3'b111, 1, 3'd2);
        b_cycle(8,  0, 3'b000, 0, 1, 1, 3'b111, 1, 3'd2);
        b_cycle(9,  0, 3'b000, 0, 1, 1, 3'b111, 1, 3'd2);
        // Release: XOR reduction goes 1 -> 0, q holds after draining.
        b_cycle(10, 0, 3'b000, 1, 1, 1, 3'b110, 0, 3'd1);
        b_cycle(11, 0, 3'b000, 1, 1, 0, 3'b110, 0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
